// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped instruction cache, one 32-bit word per set,
//   sitting between the fetch stage and the memory arbiter.
// Latency: hits are returned combinationally in the same cycle. A miss costs
//   one launch cycle plus the memory fill cycles, and the refetch hits on the
//   cycle after the FSM returns to Idle.
// Backpressure: while a fill is outstanding, iwait stalls the FSM in Update.
//   Fetch sees ihit=0 until the fill lands.
//
// Ports:
//   CLK, RST              clock (rising edge), asynchronous active-high reset
//   halt, flush           core halted (no hits, no new misses); flush pulse
//                         that invalidates all sets
//   imemREN, imemaddr     fetch read request and byte address
//                         (tag | index | offset)
//   ihit, imemload        hit indication and instruction word (0 on miss)
//   iREN, iaddr           memory read request and word-aligned address
//   iwait, iload          memory busy, and read data valid when iREN & !iwait
//   hit_count, miss_count only present when ICACHE_STATS_EN is defined
//
// Build option: define ICACHE_STATS_EN to add the saturating hit and miss
// counters.

package cache_types_pkg;
  typedef enum logic {
    IDLE   = 1'b0,
    UPDATE = 1'b1
  } state_t;
endpackage

module icache_ctrl
  import cache_types_pkg::*;
#(
  parameter int IDX_W = 4,
  parameter int TAG_W = 26
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        halt,
  input  logic        flush,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int SETS = 1 << IDX_W;

  // Fetch address layout.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [1:0]       offset;
  } icache_t;

  // Per-set tag entry.
  typedef struct packed {
    logic             v;
    logic [TAG_W-1:0] tag;
  } tag_t;

  state_t      state;
  icache_t     req;
  icache_t     miss_q;
  tag_t        tags [SETS];
  logic [31:0] data [SETS];
  tag_t        ent;
  logic        hit;
  logic        miss_go;
  logic        fill_done;

  // Fetch is word-aligned, so the byte offset does not take part in the lookup.
  logic        unused_offset;

  assign req           = icache_t'(imemaddr);
  assign unused_offset = ^req.offset;
  assign ent           = tags[req.idx];

  // Lookup is blocked while a fill is outstanding. It is also blocked on a
  // flush cycle, so the fetch stage never consumes a word that is about to be
  // invalidated.
  assign hit = imemREN & ~halt & ~flush & (state == IDLE) &
               ent.v & (ent.tag == req.tag);

  assign ihit     = hit;
  assign imemload = hit ? data[req.idx] : 32'h0;

  assign miss_go   = (state == IDLE) & imemREN & ~halt & ~hit & ~flush;
  assign fill_done = (state == UPDATE) & ~iwait;

  // Miss FSM. iREN and iaddr are registered, so the memory side sees a clean
  // request starting on the cycle after the miss is detected. iaddr holds its
  // last value once the FSM is back in Idle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state  <= IDLE;
      miss_q <= '0;
      iREN   <= 1'b0;
      iaddr  <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (miss_go) begin
            miss_q.tag    <= req.tag;
            miss_q.idx    <= req.idx;
            miss_q.offset <= 2'b00;
            iREN          <= 1'b1;
            iaddr         <= {req.tag, req.idx, 2'b00};
            state         <= UPDATE;
          end
        end
        UPDATE: begin
          // The memory transaction cannot be aborted. halt, flush and any
          // change of the fetch address are ignored until the data returns.
          if (!iwait) begin
            iREN  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          iREN  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Tag and valid array. A flush is written after the fill, so a flush that
  // lands on the fill-completion edge also clears the freshly filled entry.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < SETS; i++) begin
        tags[i] <= '0;
      end
    end else begin
      if (fill_done) begin
        tags[miss_q.idx].v   <= 1'b1;
        tags[miss_q.idx].tag <= miss_q.tag;
      end
      if (flush) begin
        for (int i = 0; i < SETS; i++) begin
          tags[i].v <= 1'b0;
        end
      end
    end
  end

  // The data array needs no reset. A word is only read when its valid bit is
  // set, and RST forces the FSM out of Update, which suppresses fill_done.
  always_ff @(posedge CLK) begin
    if (fill_done) begin
      data[miss_q.idx] <= iload;
    end
  end

`ifdef ICACHE_STATS_EN
  // Saturating event counters. flush clears them; it can never coincide with
  // a counted event, because a flush cycle blocks both hits and miss launch.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else if (flush) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      if (hit && hit_count != 32'hFFFF_FFFF) begin
        hit_count <= hit_count + 32'd1;
      end
      if (miss_go && miss_count != 32'hFFFF_FFFF) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: directed and randomized stimulus for icache_ctrl, checked
//   against a set-level reference model (valid/tag/data arrays plus one
//   pending-fill record) and a simple addressable memory.
module tb_icache_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        halt;
  logic        flush;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic        mv   [16];
  logic [25:0] mtag [16];
  logic [31:0] mdat [16];
  logic        m_busy;
  logic [31:0] m_paddr;
  logic [31:0] m_iaddr;

  icache_ctrl dut (
    .CLK      (CLK),
    .RST      (RST),
    .halt     (halt),
    .flush    (flush),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iREN     (iREN),
    .iaddr    (iaddr),
    .iwait    (iwait),
    .iload    (iload)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  always #5 CLK = ~CLK;

  // Memory contents: one fixed word for 0x40, and a hash of the address
  // everywhere else.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'hDEAD_BEEF;
    return (a * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    m_busy  = 1'b0;
    m_paddr = 32'h0;
    m_iaddr = 32'h0;
  endtask

  // Drive one cycle of inputs at the negedge, check the outputs 1ns later,
  // then advance the model across the rising edge.
  task automatic step(input logic ren, input logic [31:0] a, input logic hlt,
                      input logic fl, input logic wt);
    logic        e_hit;
    logic [3:0]  ix;
    ix       = a[5:2];
    imemREN  = ren;
    imemaddr = a;
    halt     = hlt;
    flush    = fl;
    iwait    = wt;
    iload    = memfn(m_iaddr);
    #1;
    e_hit = ren && !hlt && !fl && !m_busy && mv[ix] && (mtag[ix] == a[31:6]);
    chk("ihit", {31'h0, ihit}, {31'h0, e_hit});
    chk("imemload", imemload, e_hit ? mdat[ix] : 32'h0);
    chk("iREN", {31'h0, iREN}, {31'h0, m_busy});
    chk("iaddr", iaddr, m_iaddr);
    @(posedge CLK);
    if (m_busy) begin
      if (!wt) begin
        mdat[m_paddr[5:2]] = memfn(m_paddr);
        mtag[m_paddr[5:2]] = m_paddr[31:6];
        mv[m_paddr[5:2]]   = 1'b1;
        m_busy             = 1'b0;
      end
    end else if (ren && !hlt && !e_hit && !fl) begin
      m_busy  = 1'b1;
      m_paddr = {a[31:2], 2'b00};
      m_iaddr = m_paddr;
    end
    if (fl) for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    @(negedge CLK);
  endtask

  // Combinational look-up check without advancing the clock.
  task automatic probe(input string tag, input logic [31:0] a, input logic e_hit,
                       input logic [31:0] e_load);
    imemREN  = 1'b1;
    imemaddr = a;
    halt     = 1'b0;
    flush    = 1'b0;
    #1;
    chk({tag, "_ihit"}, {31'h0, ihit}, {31'h0, e_hit});
    chk({tag, "_load"}, imemload, e_load);
  endtask

  initial begin
    RST = 1'b1; halt = 1'b0; flush = 1'b0; imemREN = 1'b1;
    imemaddr = 32'h40; iwait = 1'b1; iload = 32'h0;
    model_reset();
    repeat (2) @(negedge CLK);
    chk("rst_ihit", {31'h0, ihit}, 32'h0);
    chk("rst_load", imemload, 32'h0);
    chk("rst_iREN", {31'h0, iREN}, 32'h0);
    chk("rst_iaddr", iaddr, 32'h0);
    RST = 1'b0;

    // Cold miss on 0x40, three wait cycles, then the fill.
    step(1, 32'h40, 0, 0, 1);
    chk("miss_iREN", {31'h0, iREN}, 32'h1);
    chk("miss_iaddr", iaddr, 32'h40);
    repeat (3) step(1, 32'h40, 0, 0, 1);
    step(1, 32'h40, 0, 0, 0);
    probe("refetch", 32'h40, 1'b1, 32'hDEAD_BEEF);
    step(1, 32'h40, 0, 0, 1);

    // Same index, new tag: the miss evicts 0x40.
    step(1, 32'h440, 0, 0, 1);
    chk("evict_iaddr", iaddr, 32'h440);
    step(1, 32'h440, 0, 0, 0);
    probe("evicted", 32'h40, 1'b0, 32'h0);
    step(1, 32'h40, 0, 0, 1);
    step(1, 32'h40, 0, 0, 0);

    // A flush pulse invalidates the entry.
    step(0, 32'h0, 0, 1, 1);
    probe("flushed", 32'h40, 1'b0, 32'h0);
    step(1, 32'h40, 0, 0, 1);
    chk("flush_reiss", {31'h0, iREN}, 32'h1);
    step(1, 32'h40, 0, 0, 0);

    // A flush on the fill-completion edge wins over the fill.
    step(1, 32'h80, 0, 0, 1);
    step(1, 32'h80, 0, 1, 0);
    probe("flush_fill", 32'h80, 1'b0, 32'h0);
    step(1, 32'h80, 0, 0, 1);
    chk("flush_fill_miss", {31'h0, iREN}, 32'h1);
    step(0, 32'h0, 0, 0, 0);

    // The fetch address changes mid-fill; the fill still targets the latched set.
    step(1, 32'h40, 0, 0, 1);
    step(1, 32'h84, 0, 0, 1);
    step(1, 32'h84, 0, 0, 0);
    step(1, 32'h84, 0, 0, 1);
    chk("chg_iaddr", iaddr, 32'h84);
    step(1, 32'h84, 0, 0, 0);
    probe("chg_idx0", 32'h40, 1'b1, 32'hDEAD_BEEF);

    // halt during Update: the fill still completes.
    step(1, 32'h100, 0, 0, 1);
    step(1, 32'h100, 1, 0, 1);
    step(0, 32'h0, 1, 0, 0);
    probe("halt_fill", 32'h100, 1'b1, memfn(32'h100));

    // Reset in the middle of an Update.
    step(1, 32'h200, 0, 0, 1);
    RST = 1'b1;
    #1;
    chk("arst_iREN", {31'h0, iREN}, 32'h0);
    chk("arst_iaddr", iaddr, 32'h0);
    @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    step(1, 32'h200, 0, 0, 1);
    chk("arst_remiss", {31'h0, iREN}, 32'h1);

    // Randomized traffic over a small address footprint, so hits are frequent.
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 2) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      step($urandom_range(0, 9) < 8, a, $urandom_range(0, 9) == 0,
           $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
